// File: rtl/cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_bus_arbiter
//
// Round-robin arbiter that shares one external CPU bus between NUM_PORTS
// masters (fetch, memory stage, DMA, video, ...). One master owns the bus at a
// time. The owner keeps the bus until the slave answers with i_bus_ready, or
// until the watchdog gives up after TIMEOUT cycles. Every transfer ends with
// one RELEASE cycle so that the finished master can drop its request before
// the next arbitration.
//
// Parameters
//   NUM_PORTS  number of requesters (2..8)
//   TIMEOUT    cycles a granted transfer may wait for i_bus_ready; 0 = no watchdog
//
// Ports
//   i_clock        clock, all state on the rising edge
//   i_reset        asynchronous active-low reset
//   i_request      per-port request, held until that port's o_ready pulse
//   i_rw           per-port direction, 1 = write
//   i_address      per-port address, port k at [32k+31:32k]
//   i_wdata        per-port write data, same packing
//   o_ready        one-cycle completion pulse to the owner
//   o_rdata        read data broadcast, valid only with o_ready
//   o_grant        one-hot current owner, zero when idle
//   o_timeout      one-cycle pulse when the watchdog aborts a transfer
//   o_bus_request  bus request
//   o_bus_rw       bus direction
//   o_bus_address  bus address
//   o_bus_wdata    bus write data
//   i_bus_ready    bus completion pulse
//   i_bus_rdata    bus read data
// -----------------------------------------------------------------------------
module cpu_bus_arbiter #(
   parameter int NUM_PORTS = 3,
   parameter int TIMEOUT   = 1023
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic [NUM_PORTS-1:0]      i_request,
   input  logic [NUM_PORTS-1:0]      i_rw,
   input  logic [32*NUM_PORTS-1:0]   i_address,
   input  logic [32*NUM_PORTS-1:0]   i_wdata,
   output logic [NUM_PORTS-1:0]      o_ready,
   output logic [31:0]               o_rdata,
   output logic [NUM_PORTS-1:0]      o_grant,
   output logic                      o_timeout,
   output logic                      o_bus_rw,
   output logic                      o_bus_request,
   input  logic                      i_bus_ready,
   output logic [31:0]               o_bus_address,
   input  logic [31:0]               i_bus_rdata,
   output logic [31:0]               o_bus_wdata
);

   localparam int PW     = $clog2(NUM_PORTS);
   // Watchdog counter is clog2(TIMEOUT+1) wide; keep one bit when disabled.
   localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int T_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   localparam logic [CW-1:0] CNT_LAST  = CW'(T_LAST);
   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      ABORT,
      RELEASE
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [PW-1:0]   owner;       // current owner, doubles as last_owner
   logic [CW-1:0]   wd_count;    // watchdog: ACTIVE cycles without ready
   logic            found;
   logic [PW-1:0]   winner;
   logic [PW:0]     cand;        // one spare bit so last_owner+i never overflows
   logic [NUM_PORTS-1:0] owner_hot;

   logic [31:0] addr_port  [NUM_PORTS];
   logic [31:0] wdata_port [NUM_PORTS];

   genvar k;
   generate
      for (k = 0; k < NUM_PORTS; k++) begin : g_unpack
         assign addr_port[k]  = i_address[32*k +: 32];
         assign wdata_port[k] = i_wdata[32*k +: 32];
      end
   endgenerate

   assign owner_hot = NUM_PORTS'(1) << owner;

   // Round-robin pick: first set request scanning owner+1, owner+2, ...
   // wrapping modulo NUM_PORTS. The sum stays below 2*NUM_PORTS, so a single
   // conditional subtract replaces the modulo.
   always_comb begin
      found  = 1'b0;
      winner = owner;
      cand   = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         cand = {1'b0, owner} + (PW+1)'(i);
         if (cand >= (PW+1)'(NUM_PORTS))
            cand = cand - (PW+1)'(NUM_PORTS);
         if (!found && i_request[cand[PW-1:0]]) begin
            found  = 1'b1;
            winner = cand[PW-1:0];
         end
      end
   end

   // NOTE: clocked processes use non-blocking assignments only, so every flop
   // samples the values that were present before the edge.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Reset owner to the last port so port 0 wins the first arbitration.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         owner    <= LAST_PORT;
         wd_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  owner    <= winner;
                  wd_count <= '0;
               end
            end
            ACTIVE: begin
               // Saturates instead of wrapping (matters only with TIMEOUT = 0).
               if (!i_bus_ready && wd_count != CNT_MAX)
                  wd_count <= wd_count + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // NOTE: every signal written here gets a default first; a branch that
   // skipped one would otherwise infer a latch.
   always_comb begin
      state_next    = state;
      o_grant       = '0;
      o_ready       = '0;
      o_timeout     = 1'b0;
      o_bus_request = 1'b0;
      o_bus_rw      = 1'b0;
      o_bus_address = '0;
      o_bus_wdata   = '0;
      o_rdata       = '0;

      case (state)
         IDLE: begin
            if (found)
               state_next = ACTIVE;
         end

         ACTIVE: begin
            o_grant       = owner_hot;
            o_bus_request = 1'b1;
            o_bus_rw      = i_rw[owner];
            o_bus_address = addr_port[owner];
            o_bus_wdata   = wdata_port[owner];
            o_rdata       = i_bus_rdata;
            if (i_bus_ready) begin
               // A requester that already gave up gets no completion pulse.
               o_ready    = owner_hot & i_request;
               state_next = RELEASE;
            end else if (TIMEOUT != 0 && wd_count == CNT_LAST) begin
               state_next = ABORT;
            end
         end

         ABORT: begin
            o_grant    = owner_hot;
            o_ready    = owner_hot & i_request;
            o_timeout  = 1'b1;
            state_next = RELEASE;
         end

         RELEASE: begin
            // One quiet cycle lets the finished requester drop i_request.
            state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_arbiter
//
// Directed scenarios plus randomized traffic for cpu_bus_arbiter
// (NUM_PORTS = 3, TIMEOUT = 8). A transfer-level reference model predicts
// every output on every cycle; directed scenarios add explicit checks.
// -----------------------------------------------------------------------------
module tb_cpu_bus_arbiter;

   localparam int N   = 3;
   localparam int TMO = 8;

   logic              i_clock = 1'b0;
   logic              i_reset;
   logic [N-1:0]      req_v;
   logic [N-1:0]      rw_v;
   logic [31:0]       addr_a  [N];
   logic [31:0]       wdata_a [N];
   logic [32*N-1:0]   i_address;
   logic [32*N-1:0]   i_wdata;
   logic              bus_ready;
   logic [31:0]       bus_rdata;

   logic [N-1:0]      o_ready;
   logic [31:0]       o_rdata;
   logic [N-1:0]      o_grant;
   logic              o_timeout;
   logic              o_bus_rw;
   logic              o_bus_request;
   logic [31:0]       o_bus_address;
   logic [31:0]       o_bus_wdata;

   always #5 i_clock = ~i_clock;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         i_address[32*k +: 32] = addr_a[k];
         i_wdata[32*k +: 32]   = wdata_a[k];
      end
   end

   cpu_bus_arbiter #(.NUM_PORTS(N), .TIMEOUT(TMO)) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_request     (req_v),
      .i_rw          (rw_v),
      .i_address     (i_address),
      .i_wdata       (i_wdata),
      .o_ready       (o_ready),
      .o_rdata       (o_rdata),
      .o_grant       (o_grant),
      .o_timeout     (o_timeout),
      .o_bus_rw      (o_bus_rw),
      .o_bus_request (o_bus_request),
      .i_bus_ready   (bus_ready),
      .o_bus_address (o_bus_address),
      .i_bus_rdata   (bus_rdata),
      .o_bus_wdata   (o_bus_wdata)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: a transfer is "owner on the bus for some cycles", then an
   // optional abort cycle, then one release cycle.
   // ---------------------------------------------------------------------------
   int m_owner;     // port holding the bus, -1 when none
   int m_last;      // last port granted
   int m_age;       // bus cycles spent without ready
   int m_after;     // cycles since the bus phase ended, 0 = still on the bus
   bit m_aborted;

   logic [N-1:0] exp_grant, exp_ready;
   logic         exp_timeout, exp_bus_req, exp_rw;
   logic [31:0]  exp_addr, exp_wdata, exp_rdata;

   logic [N-1:0] obs_grant, obs_ready;
   logic         obs_timeout, obs_bus_req, obs_rw;
   logic [31:0]  obs_addr, obs_wdata, obs_rdata;

   task automatic model_reset();
      m_owner   = -1;
      m_last    = N - 1;
      m_age     = 0;
      m_after   = 0;
      m_aborted = 1'b0;
      exp_ready = '0;
   endtask

   task automatic model_expect();
      exp_grant   = '0;
      exp_ready   = '0;
      exp_timeout = 1'b0;
      exp_bus_req = 1'b0;
      exp_rw      = 1'b0;
      exp_addr    = '0;
      exp_wdata   = '0;
      exp_rdata   = '0;
      if (m_owner >= 0) begin
         if (m_after == 0) begin
            exp_grant   = N'(1) << m_owner;
            exp_bus_req = 1'b1;
            exp_rw      = rw_v[m_owner];
            exp_addr    = addr_a[m_owner];
            exp_wdata   = wdata_a[m_owner];
            exp_rdata   = bus_rdata;
            if (bus_ready && req_v[m_owner])
               exp_ready = N'(1) << m_owner;
         end else if (m_aborted && m_after == 1) begin
            exp_grant   = N'(1) << m_owner;
            exp_timeout = 1'b1;
            if (req_v[m_owner])
               exp_ready = N'(1) << m_owner;
         end
      end
   endtask

   task automatic model_advance();
      if (m_owner < 0) begin
         for (int i = 1; i <= N; i++) begin
            int c;
            c = (m_last + i) % N;
            if (req_v[c]) begin
               m_owner   = c;
               m_last    = c;
               m_age     = 0;
               m_after   = 0;
               m_aborted = 1'b0;
               break;
            end
         end
      end else if (m_after == 0) begin
         if (bus_ready) begin
            m_after = 1;
         end else begin
            m_age++;
            if (m_age == TMO) begin
               m_after   = 1;
               m_aborted = 1'b1;
            end
         end
      end else if (m_aborted && m_after == 1) begin
         m_after = 2;
      end else begin
         m_owner = -1;
      end
   endtask

   // One clock cycle: check all outputs mid-cycle, then advance the model on
   // the rising edge. Inputs are changed by the caller 1 ns after the edge.
   task automatic step(input string tag);
      @(negedge i_clock);
      model_expect();
      obs_grant   = o_grant;
      obs_ready   = o_ready;
      obs_timeout = o_timeout;
      obs_bus_req = o_bus_request;
      obs_rw      = o_bus_rw;
      obs_addr    = o_bus_address;
      obs_wdata   = o_bus_wdata;
      obs_rdata   = o_rdata;
      check({tag, "_grant"},   32'(obs_grant),   32'(exp_grant));
      check({tag, "_ready"},   32'(obs_ready),   32'(exp_ready));
      check({tag, "_timeout"}, 32'(obs_timeout), 32'(exp_timeout));
      check({tag, "_busreq"},  32'(obs_bus_req), 32'(exp_bus_req));
      check({tag, "_rw"},      32'(obs_rw),      32'(exp_rw));
      check({tag, "_addr"},    obs_addr,         exp_addr);
      check({tag, "_wdata"},   obs_wdata,        exp_wdata);
      check({tag, "_rdata"},   obs_rdata,        exp_rdata);
      @(posedge i_clock);
      model_advance();
      #1;
   endtask

   task automatic do_reset();
      i_reset   = 1'b0;
      req_v     = '0;
      bus_ready = 1'b0;
      repeat (2) @(posedge i_clock);
      model_reset();
      #1;
      i_reset = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL sim_limit: run did not end, compared %0d", n_cmp);
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      automatic int order[$];
      automatic int busy;
      automatic bit seen;
      automatic int dead_left;

      i_reset   = 1'b0;
      req_v     = '0;
      rw_v      = '0;
      bus_ready = 1'b0;
      bus_rdata = '0;
      for (int k = 0; k < N; k++) begin
         addr_a[k]  = '0;
         wdata_a[k] = '0;
      end
      model_reset();

      // Reset state: outputs all zero while idle.
      do_reset();
      step("rst");
      check("rst_grant", 32'(obs_grant), 32'h0);
      step("rst");

      // Single port read: port 1 reads 0x1000, ready two cycles after request.
      req_v     = 3'b010;
      rw_v[1]   = 1'b0;
      addr_a[1] = 32'h0000_1000;
      step("t1");
      check("t1_no_req_yet", 32'(obs_bus_req), 32'h0);
      step("t1");
      check("t1_busreq_rise", 32'(obs_bus_req), 32'h1);
      check("t1_addr", obs_addr, 32'h0000_1000);
      bus_ready = 1'b1;
      bus_rdata = 32'h1234_5678;
      step("t1");
      check("t1_ready", 32'(obs_ready), 32'h2);
      check("t1_rdata", obs_rdata, 32'h1234_5678);
      req_v     = '0;
      bus_ready = 1'b0;
      step("t1");
      step("t1");
      check("t1_grant_clear", 32'(obs_grant), 32'h0);

      // Fairness: all ports request continuously, zero-wait slave.
      do_reset();
      req_v     = 3'b111;
      bus_ready = 1'b1;
      for (int c = 0; c < 18; c++) begin
         bus_rdata = $urandom;
         step("fair");
         if (obs_bus_req) begin
            for (int p = 0; p < N; p++)
               if (obs_grant[p]) order.push_back(p);
         end
      end
      check("fair_count", 32'(order.size()), 32'd6);
      for (int i = 0; i < 6 && i < order.size(); i++)
         check("fair_order", 32'(order[i]), 32'(i % 3));
      req_v     = '0;
      bus_ready = 1'b0;
      step("fair");
      step("fair");

      // Write forwarding: port 2 writes, other ports' fields are noise.
      req_v      = 3'b100;
      rw_v[2]    = 1'b1;
      addr_a[2]  = 32'h2000_0010;
      wdata_a[2] = 32'hCAFE_F00D;
      step("t3");
      for (int c = 0; c < 4; c++) begin
         rw_v[1:0]  = 2'($urandom);
         addr_a[0]  = $urandom;
         addr_a[1]  = $urandom;
         wdata_a[0] = $urandom;
         wdata_a[1] = $urandom;
         bus_ready  = (c == 3);
         step("t3");
         check("t3_rw", 32'(obs_rw), 32'h1);
         check("t3_wdata", obs_wdata, 32'hCAFE_F00D);
         check("t3_addr", obs_addr, 32'h2000_0010);
      end
      req_v     = '0;
      bus_ready = 1'b0;
      step("t3");
      step("t3");

      // Watchdog: dead slave, port 1 waiting behind port 0.
      do_reset();
      req_v     = 3'b011;
      bus_rdata = 32'hDEAD_BEEF;
      step("t4");
      busy = 0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         step("t4");
         if (obs_bus_req) busy++;
         if (obs_timeout) begin
            seen = 1'b1;
            check("t4_ready", 32'(obs_ready), 32'h1);
            check("t4_rdata", obs_rdata, 32'h0);
         end
      end
      check("t4_timeout_seen", 32'(seen), 32'h1);
      check("t4_busy_cycles", 32'(busy), 32'd8);
      req_v[0] = 1'b0;
      step("t4");
      step("t4");
      step("t4");
      check("t4_next_grant", 32'(obs_grant), 32'h2);
      bus_ready = 1'b1;
      step("t4");
      req_v     = '0;
      bus_ready = 1'b0;
      step("t4");
      step("t4");

      // Ready arrives on the last allowed cycle: ready wins.
      req_v     = 3'b100;
      step("t5");
      for (int c = 0; c < 7; c++) step("t5");
      bus_ready = 1'b1;
      bus_rdata = 32'h5A5A_1234;
      step("t5");
      check("t5_ready", 32'(obs_ready), 32'h4);
      check("t5_rdata", obs_rdata, 32'h5A5A_1234);
      check("t5_no_timeout", 32'(obs_timeout), 32'h0);
      req_v     = '0;
      bus_ready = 1'b0;
      step("t5");
      step("t5");

      // Reset in the middle of port 1's transfer.
      req_v     = 3'b010;
      step("t6");
      step("t6");
      req_v     = 3'b111;
      bus_ready = 1'b1;
      bus_rdata = 32'hFFFF_FFFF;
      #2;
      i_reset = 1'b0;
      #1;
      check("t6_async_busreq", 32'(o_bus_request), 32'h0);
      check("t6_async_grant",  32'(o_grant),       32'h0);
      check("t6_async_ready",  32'(o_ready),       32'h0);
      check("t6_async_addr",   o_bus_address,      32'h0);
      check("t6_async_rdata",  o_rdata,            32'h0);
      model_reset();
      bus_ready = 1'b0;
      @(posedge i_clock);
      #1;
      i_reset = 1'b1;
      step("t6");
      step("t6");
      check("t6_port0_wins", 32'(obs_grant), 32'h1);
      bus_ready = 1'b1;
      step("t6");
      req_v     = '0;
      bus_ready = 1'b0;
      step("t6");
      step("t6");

      // Randomized traffic with occasional dead-slave windows.
      do_reset();
      dead_left = 0;
      for (int c = 0; c < 2000; c++) begin
         if (dead_left > 0)
            dead_left--;
         else if ($urandom_range(0, 99) == 0)
            dead_left = $urandom_range(9, 20);
         bus_ready = (dead_left == 0) && ($urandom_range(0, 2) == 0);
         bus_rdata = $urandom;
         for (int k = 0; k < N; k++) begin
            if (req_v[k]) begin
               if (exp_ready[k] || $urandom_range(0, 99) == 0)
                  req_v[k] = 1'b0;
            end else begin
               rw_v[k]    = 1'($urandom);
               addr_a[k]  = $urandom;
               wdata_a[k] = $urandom;
               if ($urandom_range(0, 3) == 0)
                  req_v[k] = 1'b1;
            end
         end
         step("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
